spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI flash read responder: decodes the read opcode and 24-bit address from
// the byte engine, fetches 32-bit words from memory with a one-word
// prefetch, and loads one data byte per exchange.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | chip select inactive; waiting for a new transaction
// CMD      | receiving the opcode byte
// ADDR_HI  | receiving address bits [23:16]
// ADDR_MID | receiving address bits [15:8]
// ADDR_LO  | receiving address bits [7:0]; the first word fetch issues here
// STREAM   | one data byte per exchange; the next word is prefetched at lane 3
// IGNORE   | unsupported opcode; silent until chip select drops
module spi_flash_responder #(
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_active_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    output logic        tx_load_o,
    output logic [7:0]  tx_byte_o,
    output logic        mem_req_o,
    output logic [23:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        cmd_err_o,
    output logic        underrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_MID,
        ADDR_LO,
        STREAM,
        IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_load_q, tx_load_d;
    logic        cmd_err_q, cmd_err_d;
    logic        underrun_q, underrun_d;
    // A byte has been loaded for the exchange currently in progress.
    logic        loaded_q, loaded_d;
    logic        mem_req_q, mem_req_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    // Buffer that the outstanding request will fill (0 or 1).
    logic        req_buf_q, req_buf_d;
    // The outstanding request belongs to an aborted transaction; drop its data.
    logic        stale_q, stale_d;

    // Two word buffers, each tagged with its word address.
    logic [31:0] b0_data_q, b0_data_d, b1_data_q, b1_data_d;
    logic [21:0] b0_word_q, b0_word_d, b1_word_q, b1_word_d;
    logic        b0_vld_q, b0_vld_d, b1_vld_q, b1_vld_d;

    logic        hit0, hit1, hit;
    logic [31:0] hit_word;
    logic [7:0]  lane_byte;

    assign hit0     = b0_vld_q && (b0_word_q == addr_q[23:2]);
    assign hit1     = b1_vld_q && (b1_word_q == addr_q[23:2]);
    assign hit      = hit0 || hit1;
    assign hit_word = hit0 ? b0_data_q : b1_data_q;

    // Select the byte lane addressed by addr[1:0] from the held word.
    always_comb begin
        lane_byte = hit_word[7:0];
        case (addr_q[1:0])
            2'd0: lane_byte = hit_word[7:0];
            2'd1: lane_byte = hit_word[15:8];
            2'd2: lane_byte = hit_word[23:16];
            2'd3: lane_byte = hit_word[31:24];
            default: lane_byte = hit_word[7:0];
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 24'h0;
            tx_byte_q  <= FILL_BYTE;
            tx_load_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
            underrun_q <= 1'b0;
            loaded_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 24'h0;
            req_buf_q  <= 1'b0;
            stale_q    <= 1'b0;
            b0_data_q  <= 32'h0;
            b0_word_q  <= 22'h0;
            b0_vld_q   <= 1'b0;
            b1_data_q  <= 32'h0;
            b1_word_q  <= 22'h0;
            b1_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_byte_q  <= tx_byte_d;
            tx_load_q  <= tx_load_d;
            cmd_err_q  <= cmd_err_d;
            underrun_q <= underrun_d;
            loaded_q   <= loaded_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            req_buf_q  <= req_buf_d;
            stale_q    <= stale_d;
            b0_data_q  <= b0_data_d;
            b0_word_q  <= b0_word_d;
            b0_vld_q   <= b0_vld_d;
            b1_data_q  <= b1_data_d;
            b1_word_q  <= b1_word_d;
            b1_vld_q   <= b1_vld_d;
        end
    end

    // Next-state logic: memory completion first, then the transaction FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tx_byte_d  = tx_byte_q;
        tx_load_d  = 1'b0;
        cmd_err_d  = 1'b0;
        underrun_d = 1'b0;
        loaded_d   = loaded_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        req_buf_d  = req_buf_q;
        stale_d    = stale_q;
        b0_data_d  = b0_data_q;
        b0_word_d  = b0_word_q;
        b0_vld_d   = b0_vld_q;
        b1_data_d  = b1_data_q;
        b1_word_d  = b1_word_q;
        b1_vld_d   = b1_vld_q;

        // An ack only counts while a request is open; data for an aborted
        // transaction (or one ending this cycle) is dropped.
        if (mem_req_q && mem_ack_i) begin
            mem_req_d = 1'b0;
            stale_d   = 1'b0;
            if (!stale_q && cs_active_i) begin
                if (req_buf_q) begin
                    b1_data_d = mem_rdata_i;
                    b1_word_d = mem_addr_q[23:2];
                    b1_vld_d  = 1'b1;
                end else begin
                    b0_data_d = mem_rdata_i;
                    b0_word_d = mem_addr_q[23:2];
                    b0_vld_d  = 1'b1;
                end
            end
        end

        if (!cs_active_i) begin
            // CS drop wins over any same-cycle exchange.
            state_d  = IDLE;
            loaded_d = 1'b0;
            b0_vld_d = 1'b0;
            b1_vld_d = 1'b0;
            if (mem_req_q && !mem_ack_i) begin
                stale_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = CMD;
                    tx_byte_d = FILL_BYTE;
                    tx_load_d = 1'b1;
                end
                CMD: begin
                    if (rx_valid_i) begin
                        if (rx_byte_i == READ_CMD) begin
                            state_d   = ADDR_HI;
                            tx_byte_d = FILL_BYTE;
                            tx_load_d = 1'b1;
                        end else begin
                            state_d   = IGNORE;
                            cmd_err_d = 1'b1;
                        end
                    end
                end
                ADDR_HI: begin
                    if (rx_valid_i) begin
                        addr_d[23:16] = rx_byte_i;
                        state_d       = ADDR_MID;
                        tx_byte_d     = FILL_BYTE;
                        tx_load_d     = 1'b1;
                    end
                end
                ADDR_MID: begin
                    if (rx_valid_i) begin
                        addr_d[15:8] = rx_byte_i;
                        state_d      = ADDR_LO;
                        tx_byte_d    = FILL_BYTE;
                        tx_load_d    = 1'b1;
                    end
                end
                ADDR_LO: begin
                    if (rx_valid_i) begin
                        addr_d[7:0] = rx_byte_i;
                        state_d     = STREAM;
                        loaded_d    = 1'b0;
                        // If an aborted request is still open, STREAM issues
                        // the fetch once that request has completed.
                        if (!mem_req_q) begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = {addr_q[23:8], rx_byte_i[7:2], 2'b00};
                            req_buf_d  = 1'b0;
                        end
                    end
                end
                STREAM: begin
                    if (rx_valid_i) begin
                        addr_d   = addr_q + 24'd1;
                        loaded_d = 1'b0;
                        if (!loaded_q) begin
                            underrun_d = 1'b1;
                        end
                    end else if (!loaded_q && hit) begin
                        tx_byte_d = lane_byte;
                        tx_load_d = 1'b1;
                        loaded_d  = 1'b1;
                        // Last lane of the word: fetch the next word into the
                        // buffer not holding the current one.
                        if (addr_q[1:0] == 2'd3 && !mem_req_q) begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = {addr_q[23:2] + 22'd1, 2'b00};
                            req_buf_d  = hit0;
                        end
                    end else if (!hit && !mem_req_q) begin
                        // Current word neither held nor in flight.
                        mem_req_d  = 1'b1;
                        mem_addr_d = {addr_q[23:2], 2'b00};
                        req_buf_d  = 1'b0;
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign tx_load_o  = tx_load_q;
    assign tx_byte_o  = tx_byte_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign busy_o     = (state_q != IDLE);
    assign cmd_err_o  = cmd_err_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a byte-engine driver, a memory
// model with per-request latency, and scoreboards of expected tx bytes and
// expected fetch addresses.
module tb_spi_flash_responder;

    localparam logic [7:0] READ_CMD = 8'h03;
    localparam logic [7:0] FILL     = 8'hFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_active_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        tx_load_o;
    logic [7:0]  tx_byte_o;
    logic        mem_req_o;
    logic [23:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        busy_o;
    logic        cmd_err_o;
    logic        underrun_o;

    int checks = 0;
    int failures = 0;
    int mem_lat = 2;
    int cmd_err_cnt = 0;
    int underrun_cnt = 0;

    logic [7:0]  exp_tx[$];
    logic [23:0] exp_fetch[$];
    logic [31:0] mem_words[int];

    always #5 clk = ~clk;

    spi_flash_responder #(
        .READ_CMD (8'h03),
        .FILL_BYTE(8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs_active_i(cs_active_i),
        .rx_valid_i (rx_valid_i),
        .rx_byte_i  (rx_byte_i),
        .tx_load_o  (tx_load_o),
        .tx_byte_o  (tx_byte_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .busy_o     (busy_o),
        .cmd_err_o  (cmd_err_o),
        .underrun_o (underrun_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        int k;
        k = int'(a[23:2]);
        if (mem_words.exists(k)) return mem_words[k];
        return 32'h0;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [31:0] w;
        w = mem_rd(a);
        w = w >> (8 * int'(a[1:0]));
        return w[7:0];
    endfunction

    // Output monitor: tx loads against the scoreboard, pulse counters.
    task automatic out_mon();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (cmd_err_o) cmd_err_cnt++;
            if (underrun_o) underrun_cnt++;
            if (tx_load_o) begin
                if (exp_tx.size() == 0) begin
                    chk("unexpected_tx_load", {24'h0, tx_byte_o}, 32'h100);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", {24'h0, tx_byte_o}, {24'h0, e});
                end
            end
        end
    endtask

    // Memory model: one request at a time, data captured when the request
    // is first seen, ack delivered after the latency even if the request
    // is withdrawn by reset.
    task automatic mem_model();
        bit          busy = 1'b0;
        int          cnt = 0;
        logic [23:0] a = 24'h0;
        logic [31:0] data = 32'h0;
        logic [23:0] e;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (!busy && mem_req_o && !reset) begin
                busy = 1'b1;
                a    = mem_addr_o;
                cnt  = mem_lat;
                data = mem_rd(a);
                if (exp_fetch.size() == 0) begin
                    chk("unexpected_fetch", {8'h0, a}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_fetch.pop_front();
                    chk("fetch_addr", {8'h0, a}, {8'h0, e});
                end
            end else if (busy && mem_req_o) begin
                chk("mem_addr_stable", {8'h0, mem_addr_o}, {8'h0, a});
            end
            if (busy) begin
                if (cnt == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = data;
                    busy        = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    endtask

    task automatic xchg(input logic [7:0] b, input bit last, input int g);
        repeat (g) @(negedge clk);
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        if (last) cs_active_i = 1'b0;
        @(negedge clk);
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'h00;
    endtask

    // Full read: n data exchanges, the last one coinciding with CS drop;
    // data bytes before index 'first' are expected to be skipped.
    task automatic read_txn(input logic [23:0] a, input int n, input int first, input int dgap);
        repeat (4) exp_tx.push_back(FILL);
        for (int i = first; i < n; i++) exp_tx.push_back(mem_byte(a + 24'(i)));
        @(negedge clk);
        cs_active_i = 1'b1;
        xchg(READ_CMD, 1'b0, 6);
        xchg(a[23:16], 1'b0, 6);
        xchg(a[15:8], 1'b0, 6);
        xchg(a[7:0], 1'b0, 6);
        for (int i = 0; i < n; i++) xchg(8'h00, (i == n - 1), dgap);
        repeat (3) @(negedge clk);
        chk("busy_after_txn", 32'(busy_o), 32'h0);
    endtask

    initial begin
        int c0;
        int u0;
        fork
            out_mon();
            mem_model();
        join_none

        // Reset values
        @(negedge clk);
        chk("rst_tx_byte", {24'h0, tx_byte_o}, {24'h0, FILL});
        chk("rst_tx_load", 32'(tx_load_o), 32'h0);
        chk("rst_mem_req", 32'(mem_req_o), 32'h0);
        chk("rst_mem_addr", {8'h0, mem_addr_o}, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_flags", {30'h0, cmd_err_o, underrun_o}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // rx_valid while idle does nothing
        rx_valid_i = 1'b1;
        rx_byte_i  = READ_CMD;
        @(negedge clk);
        rx_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_rx_busy", 32'(busy_o), 32'h0);

        // Aligned read of word 0
        mem_words[0] = 32'hDDCCBBAA;
        exp_fetch.push_back(24'h000000);
        exp_fetch.push_back(24'h000004);
        read_txn(24'h000000, 4, 0, 6);
        repeat (20) @(negedge clk);

        // Unaligned start crossing into the prefetched word
        mem_words[0] = 32'h44332211;
        mem_words[1] = 32'h88776655;
        exp_fetch.push_back(24'h000000);
        exp_fetch.push_back(24'h000004);
        read_txn(24'h000002, 4, 0, 6);
        repeat (20) @(negedge clk);

        // Address wrap at the top of the 24-bit space
        mem_words[32'h3FFFFF] = 32'hF4F3F2F1;
        exp_fetch.push_back(24'hFFFFFC);
        exp_fetch.push_back(24'h000000);
        read_txn(24'hFFFFFE, 4, 0, 6);
        repeat (20) @(negedge clk);

        // Unsupported opcode
        c0 = cmd_err_cnt;
        exp_tx.push_back(FILL);
        @(negedge clk);
        cs_active_i = 1'b1;
        xchg(8'h0B, 1'b0, 6);
        repeat (2) @(negedge clk);
        chk("busy_in_ignore", 32'(busy_o), 32'h1);
        xchg(8'h00, 1'b0, 6);
        xchg(8'h00, 1'b0, 6);
        chk("busy_still_ignore", 32'(busy_o), 32'h1);
        cs_active_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_ignore", 32'(busy_o), 32'h0);
        chk("cmd_err_once", 32'(cmd_err_cnt - c0), 32'h1);
        repeat (10) @(negedge clk);

        // Slow memory: first data exchange underruns, stream resumes at addr+1
        mem_words[4] = 32'h5A4B3C2D;
        mem_lat = 8;
        u0 = underrun_cnt;
        exp_fetch.push_back(24'h000010);
        exp_fetch.push_back(24'h000014);
        read_txn(24'h000010, 4, 1, 6);
        chk("underrun_once", 32'(underrun_cnt - u0), 32'h1);
        repeat (30) @(negedge clk);

        // CS drop with a request open; stale data must not be used
        mem_words[32'h40] = 32'h11223344;
        mem_lat = 50;
        exp_fetch.push_back(24'h000100);
        repeat (4) exp_tx.push_back(FILL);
        @(negedge clk);
        cs_active_i = 1'b1;
        xchg(READ_CMD, 1'b0, 6);
        xchg(8'h00, 1'b0, 6);
        xchg(8'h01, 1'b0, 6);
        xchg(8'h00, 1'b0, 6);
        repeat (3) @(negedge clk);
        chk("req_open_before_drop", 32'(mem_req_o), 32'h1);
        cs_active_i = 1'b0;
        mem_lat = 2;
        repeat (3) @(negedge clk);
        chk("req_held_after_drop", 32'(mem_req_o), 32'h1);
        chk("idle_after_drop", 32'(busy_o), 32'h0);
        mem_words[32'h40] = 32'hA0B0C0D0;
        exp_fetch.push_back(24'h000100);
        exp_fetch.push_back(24'h000104);
        read_txn(24'h000100, 4, 0, 30);
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-transaction with a request open
        mem_lat = 20;
        exp_fetch.push_back(24'h000020);
        repeat (4) exp_tx.push_back(FILL);
        @(negedge clk);
        cs_active_i = 1'b1;
        xchg(READ_CMD, 1'b0, 6);
        xchg(8'h00, 1'b0, 6);
        xchg(8'h00, 1'b0, 6);
        xchg(8'h20, 1'b0, 6);
        repeat (3) @(negedge clk);
        chk("req_before_reset", 32'(mem_req_o), 32'h1);
        #2;
        reset = 1'b1;
        cs_active_i = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req_o), 32'h0);
        chk("async_rst_busy", 32'(busy_o), 32'h0);
        chk("async_rst_mem_addr", {8'h0, mem_addr_o}, 32'h0);
        chk("async_rst_tx_byte", {24'h0, tx_byte_o}, {24'h0, FILL});
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("req_low_after_stale_ack", 32'(mem_req_o), 32'h0);
        chk("busy_low_after_stale_ack", 32'(busy_o), 32'h0);
        mem_lat = 2;
        mem_words[1] = 32'h88776655;
        exp_fetch.push_back(24'h000004);
        read_txn(24'h000004, 2, 0, 6);
        repeat (20) @(negedge clk);

        chk("tx_queue_drained", 32'(exp_tx.size()), 32'h0);
        chk("fetch_queue_drained", 32'(exp_fetch.size()), 32'h0);
        chk("underrun_total", 32'(underrun_cnt), 32'h1);
        chk("cmd_err_total", 32'(cmd_err_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
